// File: rtl/sgpio_frame_gen_pkg.sv
// Shared definitions for the SGPIO frame generator: FSM states, per-drive bit kinds, defaults.
// The optional SDIN capture path is enabled by defining SGPIO_SDIN_EN.
package sgpio_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Bit-kind codes; they equal the bit positions inside drive_bits_t.
    localparam int unsigned KIND_ACT       = 0;
    localparam int unsigned KIND_LOC       = 1;
    localparam int unsigned KIND_FLT       = 2;
    localparam int unsigned BITS_PER_DRIVE = 3;

    localparam int unsigned DEF_HDD_NUM    = 8;
    localparam int unsigned BIT_CNT_W      = 8;

    typedef struct packed {
        logic flt;
        logic loc;
        logic act;
    } drive_bits_t;

endpackage

// File: rtl/sgpio_clk_div.sv
// SGPIO bit clock generator: SCLK idles high, toggles every CLK_DIV cycles while run_i is set,
// and flags the cycle before each SCLK edge with a one-cycle rise/fall strobe.
module sgpio_clk_div #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic SYSCLK,
    input  logic RESET_N,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;
    logic             wrap_c;

    assign wrap_c   = run_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign fall_c_o = wrap_c && sclk_q;
    assign rise_c_o = wrap_c && !sclk_q;
    assign sclk_o   = sclk_q;

    // Divider is parked at zero with SCLK high whenever the frame engine is idle.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else if (!run_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else if (wrap_c) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sgpio_frame_gen.sv
// SGPIO initiator: sequences LOAD -> data -> gap frames carrying per-drive ACT/LOC/FLT status.
// Define SGPIO_SDIN_EN to add SDIN capture with SDIN_DATA/SDIN_VLD outputs.
module sgpio_frame_gen
    import sgpio_frame_gen_pkg::*;
#(
    parameter int unsigned HDD_NUM  = DEF_HDD_NUM,
    parameter int unsigned CLK_DIV  = 125,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic                 SYSCLK,
    input  logic                 RESET_N,
    input  logic                 EN,
    input  logic [HDD_NUM-1:0]   ACT_IN,
    input  logic [HDD_NUM-1:0]   LOC_IN,
    input  logic [HDD_NUM-1:0]   FLT_IN,
`ifdef SGPIO_SDIN_EN
    input  logic                 SDIN,
    output logic [3*HDD_NUM-1:0] SDIN_DATA,
    output logic                 SDIN_VLD,
`endif
    output logic                 SCLK,
    output logic                 SLOAD,
    output logic                 SDOUT,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int unsigned NBITS = BITS_PER_DRIVE * HDD_NUM;

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]       shreg_q, shreg_d;
    logic                   sload_q, sload_d;
    logic                   sdout_q, sdout_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   start_frame;

    logic                   rise_c, fall_c, last_bit_c, last_gap_c;
    drive_bits_t [HDD_NUM-1:0] snap_c;

    sgpio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .SYSCLK   (SYSCLK),
        .RESET_N  (RESET_N),
        .run_i    (state_q != ST_IDLE),
        .sclk_o   (SCLK),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    // Interleave drive status so serial bit 3*i+kind is drive i; drive 0 shifts out first.
    always_comb begin
        snap_c = '0;
        for (int i = 0; i < int'(HDD_NUM); i++) begin
            snap_c[i] = '{flt: FLT_IN[i], loc: LOC_IN[i], act: ACT_IN[i]};
        end
    end

    assign last_bit_c = (bit_cnt_q == BIT_CNT_W'(NBITS - 1));
    assign last_gap_c = (bit_cnt_q == BIT_CNT_W'(GAP_BITS - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        sload_d     = sload_q;
        sdout_d     = sdout_q;
        done_d      = 1'b0;
        start_frame = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (EN) start_frame = 1'b1;
            end
            ST_LOAD: begin
                if (rise_c) begin
                    state_d = ST_SHIFT;
                    sload_d = 1'b0;
                    sdout_d = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            ST_SHIFT: begin
                if (fall_c && last_bit_c) done_d = 1'b1;
                if (rise_c) begin
                    if (last_bit_c) begin
                        state_d   = ST_GAP;
                        bit_cnt_d = '0;
                        sdout_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        sdout_d   = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            ST_GAP: begin
                if (rise_c) begin
                    if (!last_gap_c) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (EN) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // LOAD entry snapshots the status inputs; later input changes wait for the next frame.
        if (start_frame) begin
            state_d   = ST_LOAD;
            bit_cnt_d = '0;
            shreg_d   = snap_c;
            sload_d   = 1'b1;
            sdout_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sload_q   <= 1'b0;
            sdout_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sload_q   <= sload_d;
            sdout_q   <= sdout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SLOAD      = sload_q;
    assign SDOUT      = sdout_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;

`ifdef SGPIO_SDIN_EN
    logic [NBITS-1:0] shadow_q, shadow_nxt_c, sdin_data_q;
    logic             sdin_vld_q;
    logic             sample_c;

    // SDIN enters at the MSB so the first sampled bit ends up in bit 0.
    assign sample_c     = fall_c && (state_q == ST_SHIFT);
    assign shadow_nxt_c = {SDIN, shadow_q[NBITS-1:1]};

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_q    <= '0;
            sdin_data_q <= '0;
            sdin_vld_q  <= 1'b0;
        end else begin
            if (sample_c) shadow_q <= shadow_nxt_c;
            if (done_d) sdin_data_q <= shadow_nxt_c;
            sdin_vld_q <= done_d;
        end
    end

    assign SDIN_DATA = sdin_data_q;
    assign SDIN_VLD  = sdin_vld_q;
`endif

endmodule

// File: tb/tb_sgpio_frame_gen.sv
// Scoreboard bench for sgpio_frame_gen: stimulus queues expected serial frames from a status model,
// a negedge monitor decodes SCLK/SLOAD/SDOUT and compares.
module tb_sgpio_frame_gen;

    localparam int HDD   = 4;
    localparam int DIV   = 4;
    localparam int GAP   = 2;
    localparam int NB    = 3 * HDD;
    localparam int FRAME = (1 + NB + GAP) * 2 * DIV;

    logic           SYSCLK, RESET_N, EN;
    logic [HDD-1:0] ACT_IN, LOC_IN, FLT_IN;
    logic           SCLK, SLOAD, SDOUT, BUSY, FRAME_DONE;

    int n_checks = 0;
    int n_errors = 0;
    int frames_pushed = 0;
    int frames_seen = 0;
    logic [NB-1:0] exp_q[$];

    // Monitor state
    logic          prev_sclk = 1'b1, prev_sload = 1'b0, prev_sdout = 1'b0;
    bit            in_frame = 1'b0;
    int            fall_idx = NB;
    int            gap_cnt = 0, sload_run = 0, low_run = 0;
    logic [NB-1:0] got;

`ifdef SGPIO_SDIN_EN
    logic          SDIN;
    logic [NB-1:0] SDIN_DATA;
    logic          SDIN_VLD;
    logic [NB-1:0] sdin_pat = 12'hA5C;
    assign SDIN = (fall_idx < NB) ? sdin_pat[fall_idx] : 1'b0;
`endif

    sgpio_frame_gen #(.HDD_NUM(HDD), .CLK_DIV(DIV), .GAP_BITS(GAP)) dut (
        .SYSCLK     (SYSCLK),
        .RESET_N    (RESET_N),
        .EN         (EN),
        .ACT_IN     (ACT_IN),
        .LOC_IN     (LOC_IN),
        .FLT_IN     (FLT_IN),
`ifdef SGPIO_SDIN_EN
        .SDIN       (SDIN),
        .SDIN_DATA  (SDIN_DATA),
        .SDIN_VLD   (SDIN_VLD),
`endif
        .SCLK       (SCLK),
        .SLOAD      (SLOAD),
        .SDOUT      (SDOUT),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial order from the status rules: bit k carries drive k/3, kind k%3 (ACT, LOC, FLT).
    function automatic logic [NB-1:0] model(input logic [HDD-1:0] a, input logic [HDD-1:0] l,
                                            input logic [HDD-1:0] f);
        logic [NB-1:0] s;
        for (int k = 0; k < NB; k++) begin
            case (k % 3)
                0:       s[k] = a[k / 3];
                1:       s[k] = l[k / 3];
                default: s[k] = f[k / 3];
            endcase
        end
        return s;
    endfunction

    task automatic push_frame();
        exp_q.push_back(model(ACT_IN, LOC_IN, FLT_IN));
        frames_pushed++;
    endtask

    // Advance cycle by cycle until a new SLOAD pulse starts; returns the cycle index reached.
    task automatic wait_sload_rise(input int start_t, output int t);
        t = start_t;
        do begin
            @(posedge SYSCLK); #1;
            t++;
        end while (!SLOAD && t < start_t + 4 * FRAME);
    endtask

    task automatic wait_idle(input int start_t, output int t);
        t = start_t;
        while (BUSY && t < start_t + 4 * FRAME) begin
            @(posedge SYSCLK); #1;
            t++;
        end
    endtask

    always @(negedge SYSCLK) begin
        logic fell, rose, exp_done;
        if (!RESET_N) begin
            in_frame   = 1'b0;
            fall_idx   = NB;
            gap_cnt    = 0;
            sload_run  = 0;
            low_run    = 0;
            prev_sclk  = 1'b1;
            prev_sload = 1'b0;
            prev_sdout = 1'b0;
        end else begin
            fell     = prev_sclk && !SCLK;
            rose     = !prev_sclk && SCLK;
            exp_done = 1'b0;

            if (SLOAD !== prev_sload || SDOUT !== prev_sdout)
                chk("launch_with_sclk_high", 32'(SCLK), 32'd1);
            if (rose) begin
                if (low_run != 0) chk("sclk_low_width", 32'(low_run), 32'(DIV));
                low_run = 0;
            end
            if (!SCLK) low_run++;
            if (SLOAD) sload_run++;
            else if (prev_sload) begin
                chk("sload_width", 32'(sload_run), 32'(2 * DIV));
                sload_run = 0;
            end

            if (fell) begin
                if (SLOAD) begin
                    in_frame = 1'b1;
                    fall_idx = 0;
                    gap_cnt  = 0;
                end else if (in_frame && fall_idx < NB) begin
                    got[fall_idx] = SDOUT;
                    if (fall_idx == NB - 1) begin
                        exp_done = 1'b1;
                        frames_seen++;
                        if (exp_q.size() == 0) chk("frame_unexpected", 32'(got), 32'hFFFF_FFFF);
                        else chk("frame_data", 32'(got), 32'(exp_q.pop_front()));
                    end
                    fall_idx++;
                end else if (in_frame) begin
                    chk("gap_sdout", 32'(SDOUT), 32'd0);
                    gap_cnt++;
                    if (gap_cnt == GAP) in_frame = 1'b0;
                end
            end

            if (FRAME_DONE || exp_done) chk("frame_done", 32'(FRAME_DONE), 32'(exp_done));
`ifdef SGPIO_SDIN_EN
            if (SDIN_VLD || exp_done) chk("sdin_vld", 32'(SDIN_VLD), 32'(exp_done));
            if (exp_done) chk("sdin_data", 32'(SDIN_DATA), 32'(sdin_pat));
`endif
            prev_sclk  = SCLK;
            prev_sload = SLOAD;
            prev_sdout = SDOUT;
        end
    end

    initial begin
        int t, d, guard;
        RESET_N = 1'b0;
        EN      = 1'b0;
        ACT_IN  = '0;
        LOC_IN  = '0;
        FLT_IN  = '0;
        repeat (3) @(posedge SYSCLK);
        #1;
        chk("reset_state", 32'({SCLK, SLOAD, SDOUT, BUSY, FRAME_DONE}), 32'b10000);
        RESET_N = 1'b1;

        // Idle with EN low: bus parked.
        for (int i = 0; i < 200; i++) begin
            @(posedge SYSCLK); #1;
            chk("idle_hold", 32'({SCLK, SLOAD, SDOUT, BUSY}), 32'b1000);
        end

        // Single frame from a one-cycle EN pulse.
        ACT_IN = 4'b0001; LOC_IN = 4'b0000; FLT_IN = 4'b1000;
        EN = 1'b1;
        push_frame();
        @(posedge SYSCLK); #1;
        EN = 1'b0;
        chk("load_latency", 32'(SLOAD), 32'd1);
        t = 0;
        d = -1;
        while (BUSY && t < 4 * FRAME) begin
            @(posedge SYSCLK); #1;
            t++;
            if (FRAME_DONE && d < 0) d = t;
        end
        chk("frame_done_cycle", 32'(d), 32'd100);
        chk("idle_return_cycle", 32'(t), 32'(FRAME));

        // Continuous frames; mid-frame input change only affects the following frame.
        ACT_IN = 4'b0001; LOC_IN = 4'b0110; FLT_IN = 4'b0000;
        EN = 1'b1;
        push_frame();
        @(posedge SYSCLK); #1;
        chk("b2b_load", 32'(SLOAD), 32'd1);
        repeat (30) @(posedge SYSCLK);
        #1;
        ACT_IN = 4'b1111;
        push_frame();
        wait_sload_rise(30, t);
        chk("frame_period", 32'(t), 32'(FRAME));

        for (int r = 0; r < 6; r++) begin
            d = int'($urandom_range(1, 110));
            repeat (d) @(posedge SYSCLK);
            #1;
            ACT_IN = 4'($urandom());
            LOC_IN = 4'($urandom());
            FLT_IN = 4'($urandom());
            push_frame();
            wait_sload_rise(d, t);
            chk("frame_period_rand", 32'(t), 32'(FRAME));
        end

        // EN dropped mid-frame: the frame and its gap still complete.
        d = int'($urandom_range(1, 110));
        repeat (d) @(posedge SYSCLK);
        #1;
        EN = 1'b0;
        ACT_IN = 4'($urandom());
        wait_idle(d, t);
        chk("en_drop_no_truncate", 32'(t), 32'(FRAME));
        repeat (20) @(posedge SYSCLK);
        #1;
        chk("stays_idle", 32'({SCLK, SLOAD, BUSY}), 32'b100);

        // Reset in the middle of SHIFT aborts the frame at once.
        ACT_IN = 4'($urandom()); LOC_IN = 4'($urandom()); FLT_IN = 4'($urandom());
        EN = 1'b1;
        push_frame();
        @(posedge SYSCLK); #1;
        chk("pre_reset_load", 32'(SLOAD), 32'd1);
        repeat (50) @(posedge SYSCLK);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("async_reset", 32'({SCLK, SLOAD, SDOUT, BUSY, FRAME_DONE}), 32'b10000);
        frames_pushed -= exp_q.size();
        exp_q.delete();
        repeat (3) @(posedge SYSCLK);
        #1;
        ACT_IN = 4'b1010; LOC_IN = 4'b0101; FLT_IN = 4'b0011;
        push_frame();
        RESET_N = 1'b1;
        @(posedge SYSCLK); #1;
        chk("post_reset_load", 32'(SLOAD), 32'd1);
        EN = 1'b0;
        wait_idle(0, t);
        chk("post_reset_frame_len", 32'(t), 32'(FRAME));

        guard = 0;
        while ((exp_q.size() != 0 || in_frame) && guard < 4 * FRAME) begin
            @(posedge SYSCLK); #1;
            guard++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("frames_seen", 32'(frames_seen), 32'(frames_pushed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
